// File: rtl/fp16_unpack_t.sv
// Two-stage streaming unpacker: fp16 word -> sign, unbiased 6-bit exponent and 28-bit fixed mantissa.
// Keeps saturating counts of accepted words and of accepted inf/NaN words.
module fp16_unpack_t #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [27:0]          out_z,
  output logic [5:0]           out_a_e,
  output logic                 out_sign,
  output logic                 out_zero,
  output logic                 out_inf,
  output logic                 out_nan,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [CNT_WIDTH-1:0] special_cnt
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic        w_s2_adv;
  logic        w_s1_adv;
  logic        w_in_xfer;
  logic        w_in_special;

  logic        r_s1_valid;
  logic [15:0] r_s1_data;
  logic        r_s1_exp_zero;
  logic        r_s1_exp_max;
  logic        r_s1_man_zero;

  logic        r_s2_valid;
  logic [27:0] r_z;
  logic [5:0]  r_a_e;
  logic        r_sign;
  logic        r_zero;
  logic        r_inf;
  logic        r_nan;

  logic [CNT_WIDTH-1:0] r_word_cnt;
  logic [CNT_WIDTH-1:0] r_special_cnt;

  logic [4:0]  w_exp;
  logic [9:0]  w_man;
  logic [27:0] w_z;
  logic [5:0]  w_a_e;
  logic        w_zero;
  logic        w_inf;
  logic        w_nan;

  assign w_s2_adv     = !r_s2_valid || out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign in_ready     = w_s1_adv;
  assign w_in_xfer    = in_valid && w_s1_adv;
  assign w_in_special = (in_data[14:10] == 5'h1F);

  // Stage 1: capture the word plus the exponent/mantissa class bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_data     <= '0;
      r_s1_exp_zero <= 1'b0;
      r_s1_exp_max  <= 1'b0;
      r_s1_man_zero <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data     <= in_data;
        r_s1_exp_zero <= (in_data[14:10] == 5'h00);
        r_s1_exp_max  <= w_in_special;
        r_s1_man_zero <= (in_data[9:0] == 10'h000);
      end
    end
  end

  assign w_exp = r_s1_data[14:10];
  assign w_man = r_s1_data[9:0];

  // Zero and subnormal share the -14 exponent; inf/NaN report +16 so the packer saturates.
  always_comb begin
    w_a_e  = {1'b0, w_exp} - 6'd15;
    w_z    = {17'b0, 1'b1, w_man};
    w_zero = 1'b0;
    w_inf  = 1'b0;
    w_nan  = 1'b0;
    if (r_s1_exp_zero) begin
      w_a_e  = 6'h32;
      w_z    = {17'b0, 1'b0, w_man};
      w_zero = r_s1_man_zero;
    end else if (r_s1_exp_max) begin
      w_a_e = 6'h10;
      w_inf = r_s1_man_zero;
      w_nan = !r_s1_man_zero;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_z        <= '0;
      r_a_e      <= '0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_inf      <= 1'b0;
      r_nan      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_z    <= w_z;
        r_a_e  <= w_a_e;
        r_sign <= r_s1_data[15];
        r_zero <= w_zero;
        r_inf  <= w_inf;
        r_nan  <= w_nan;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word_cnt    <= '0;
      r_special_cnt <= '0;
    end else if (w_in_xfer) begin
      if (r_word_cnt != CntMax) r_word_cnt <= r_word_cnt + CntOne;
      if (w_in_special && (r_special_cnt != CntMax)) r_special_cnt <= r_special_cnt + CntOne;
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_z       = r_z;
  assign out_a_e     = r_a_e;
  assign out_sign    = r_sign;
  assign out_zero    = r_zero;
  assign out_inf     = r_inf;
  assign out_nan     = r_nan;
  assign word_cnt    = r_word_cnt;
  assign special_cnt = r_special_cnt;

endmodule
